// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS core front end.
//   fetch_state_t     - fetch FSM states (INIT, RUN, HALT)
//   NOP_WORD          - instruction word used for pipeline bubbles
//   DEFAULT_HALT_WORD - fetched word that stops fetch
//   DEFAULT_PC_STEP   - byte increment per sequential fetch
package mips_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam int unsigned DEFAULT_PC_STEP   = 4;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   load                    - capture valid_in/instr_in/pc_in/pc4_in
//   bubble                  - clear valid and instr (pc fields hold)
//   kill                    - clear valid only (all other fields hold)
//   valid_in .. pc4_in      - next contents when loading
//   valid, instr, pc, pc4   - registered contents
// Priority: bubble > load > kill > hold.
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic        kill,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc4_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_WORD;
      pc    <= 32'd0;
      pc4   <= 32'd0;
    end else if (bubble) begin
      valid <= 1'b0;
      instr <= NOP_WORD;
    end else if (load) begin
      valid <= valid_in;
      instr <= instr_in;
      pc    <= pc_in;
      pc4   <= pc4_in;
    end else if (kill) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage (PC, next-PC mux, FSM, cycle counter).
// Ports:
//   clk, rst_n                  - core clock, async active-low reset
//   pc_init                     - start address loaded on leaving INIT
//   stall, flush                - hold PC/IF/ID; drop IF/ID valid
//   redirect_valid/redirect_pc  - taken branch/jump and its target
//   imem_addr/imem_rdata        - instruction memory (combinational read)
//   program_counter             - current PC
//   ifid_valid/instr/pc/pc4     - IF/ID pipeline register
//   halted, fault               - fetch stopped; stopped by misaligned redirect
//   cycle_count                 - saturating count of non-halted cycles
//
// state   | meaning
// --------+-----------------------------------------------
// ST_INIT | first cycle after reset, PC <= pc_init
// ST_RUN  | fetching; redirect > stall > halt word > step
// ST_HALT | everything frozen until reset
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD,
  parameter int unsigned PC_STEP   = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_init,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] program_counter,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] cycle_count
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  cnt_q;
  logic         ifid_load, ifid_bubble, ifid_kill, ifid_valid_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      pc_q    <= 32'd0;
      fault_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      if (state_q != ST_HALT && cnt_q != 32'hFFFF_FFFF)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_kill     = 1'b0;
    ifid_valid_in = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_RUN;
        pc_d    = pc_init;
      end
      ST_RUN: begin
        if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
          state_d   = ST_HALT;
          fault_d   = 1'b1;
          ifid_kill = 1'b1;
        end else if (redirect_valid) begin
          // Redirect wins over stall: the in-flight fetch is squashed.
          pc_d        = redirect_pc;
          ifid_bubble = 1'b1;
        end else if (stall) begin
          ifid_kill = flush;
        end else if (imem_rdata == HALT_WORD && !flush) begin
          state_d   = ST_HALT;
          ifid_kill = 1'b1;
        end else begin
          pc_d          = pc_q + STEP;
          ifid_load     = 1'b1;
          ifid_valid_in = !flush;
        end
      end
      default: ;
    endcase
  end

  ifid_reg u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .kill     (ifid_kill),
    .valid_in (ifid_valid_in),
    .instr_in (imem_rdata),
    .pc_in    (pc_q),
    .pc4_in   (pc_q + 32'd4),
    .valid    (ifid_valid),
    .instr    (ifid_instr),
    .pc       (ifid_pc),
    .pc4      (ifid_pc4)
  );

  assign imem_addr       = pc_q;
  assign program_counter = pc_q;
  assign halted          = (state_q == ST_HALT);
  assign fault           = fault_q;
  assign cycle_count     = cnt_q;

endmodule
